// File: rtl/vproc_mem_slave.sv
// Memory-mapped slave for the VProc bus with programmable read/write wait states.
// Optional countdown interrupt timer enabled by defining VPROC_MEM_TIMER_IRQ_EN.
module vproc_mem_slave #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned RD_WAIT    = 2,
    parameter int unsigned WR_WAIT    = 1,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF,
    parameter logic [31:0] TIMER_ADDR = 32'hFFFF_FFF0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic        RD,
    input  logic [31:0] DataOut,
    output logic [31:0] DataIn,
    output logic        WRAck,
    output logic        RDAck,
    input  logic        Update,
    output logic        UpdateResponse,
    output logic [2:0]  Interrupt
);

    localparam logic [7:0] RD_W = 8'(RD_WAIT);
    localparam logic [7:0] WR_W = 8'(WR_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t      state, next_state;
    logic [7:0]  cnt, cnt_nxt;
    logic [31:2] lat_addr;
    logic [31:0] lat_data;
    logic        lat_wr;

    logic        take_req;
    logic        commit;
    logic [31:2] op_addr;
    logic [31:0] op_data;
    logic        op_wr;
    logic        in_win;
    logic        hit_tmr;
    logic        mem_we;
    logic [31:0] rd_val;
    logic [ADDR_BITS-1:0] word;

    logic [31:0] mem [2**ADDR_BITS];

    logic addr_lsb_unused;
    assign addr_lsb_unused = ^Addr[1:0];

    assign UpdateResponse = Update;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        take_req   = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (WE || RD) begin
                    take_req = 1'b1;
                    cnt_nxt  = WE ? WR_W : RD_W;
                    if (cnt_nxt == 8'd0) begin
                        next_state = ACK;
                        commit     = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 8'd1;
                if (cnt <= 8'd1) begin
                    next_state = ACK;
                    commit     = 1'b1;
                end
            end
            ACK: begin
                // Strobes still show the old command here, so they are ignored.
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (Reset) begin
            commit = 1'b0;
        end
    end

    // A zero-wait request commits on its first edge, so use the live bus then.
    assign op_addr = take_req ? Addr[31:2] : lat_addr;
    assign op_data = take_req ? DataOut    : lat_data;
    assign op_wr   = take_req ? WE         : lat_wr;

    assign in_win = (op_addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
    assign word   = op_addr[ADDR_BITS+1:2];
    assign mem_we = commit && op_wr && in_win && !hit_tmr;

`ifdef VPROC_MEM_TIMER_IRQ_EN
    localparam logic [31:0] TIMER_CLR_ADDR = TIMER_ADDR + 32'd4;

    logic [2:0]  tmr_level;
    logic [28:0] tmr_count;
    logic        hit_load;
    logic        hit_clr;
    logic        tmr_load;
    logic        tmr_clr;
    logic        tmr_fire;

    assign hit_load = (op_addr == TIMER_ADDR[31:2]);
    assign hit_clr  = (op_addr == TIMER_CLR_ADDR[31:2]);
    assign hit_tmr  = hit_load || hit_clr;
    assign tmr_load = commit && op_wr && hit_load;
    assign tmr_clr  = commit && op_wr && hit_clr;
    assign tmr_fire = !tmr_load && (tmr_count == 29'd1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tmr_level <= '0;
            tmr_count <= '0;
            Interrupt <= '0;
        end else begin
            if (tmr_load) begin
                tmr_level <= op_data[31:29];
                tmr_count <= op_data[28:0];
            end else if (tmr_count != 29'd0) begin
                tmr_count <= tmr_count - 29'd1;
            end
            // Expiry wins over a simultaneous clear so the event is never lost.
            if (tmr_fire) begin
                Interrupt <= tmr_level;
            end else if (tmr_clr) begin
                Interrupt <= '0;
            end
        end
    end

    always_comb begin
        rd_val = ERR_DATA;
        if (hit_load) begin
            rd_val = {tmr_level, tmr_count};
        end else if (hit_clr) begin
            rd_val = ERR_DATA;
        end else if (in_win) begin
            rd_val = mem[word];
        end
    end
`else
    assign hit_tmr   = 1'b0;
    assign Interrupt = 3'b000;

    always_comb begin
        rd_val = ERR_DATA;
        if (in_win) begin
            rd_val = mem[word];
        end
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
            DataIn   <= '0;
            WRAck    <= 1'b0;
            RDAck    <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            WRAck <= commit && op_wr;
            RDAck <= commit && !op_wr;
            if (take_req) begin
                lat_addr <= Addr[31:2];
                lat_data <= DataOut;
                lat_wr   <= WE;
            end
            if (commit && !op_wr) begin
                DataIn <= rd_val;
            end
        end
    end

    // Contents survive reset; only a committed write changes them.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[word] <= op_data;
        end
    end

endmodule

// File: tb/tb_vproc_mem_slave.sv
// Randomized self-checking bench for vproc_mem_slave against a transaction-level model.
// Timer checks run only when VPROC_MEM_TIMER_IRQ_EN is defined.
module tb_vproc_mem_slave;

    localparam int unsigned ADDR_BITS = 10;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int unsigned RD_WAIT   = 2;
    localparam int unsigned WR_WAIT   = 1;
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
    localparam logic [31:0] TMR_ADDR  = 32'hFFFF_FFF0;

    logic        Clk;
    logic        Reset;
    logic [31:0] Addr;
    logic        WE;
    logic        RD;
    logic [31:0] DataOut;
    logic [31:0] DataIn;
    logic        WRAck;
    logic        RDAck;
    logic        Update;
    logic        UpdateResponse;
    logic [2:0]  Interrupt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [int];
    logic [31:0] last_rd;
    logic [31:0] tmr_exp;

    vproc_mem_slave #(
        .ADDR_BITS (ADDR_BITS),
        .BASE_ADDR (BASE_ADDR),
        .RD_WAIT   (RD_WAIT),
        .WR_WAIT   (WR_WAIT),
        .ERR_DATA  (ERR_DATA),
        .TIMER_ADDR(TMR_ADDR)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Addr          (Addr),
        .WE            (WE),
        .RD            (RD),
        .DataOut       (DataOut),
        .DataIn        (DataIn),
        .WRAck         (WRAck),
        .RDAck         (RDAck),
        .Update        (Update),
        .UpdateResponse(UpdateResponse),
        .Interrupt     (Interrupt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a >> (ADDR_BITS + 2)) == (BASE_ADDR >> (ADDR_BITS + 2));
    endfunction

    function automatic bit is_timer(input logic [31:0] a);
`ifdef VPROC_MEM_TIMER_IRQ_EN
        return (a >> 2) == (TMR_ADDR >> 2) || (a >> 2) == ((TMR_ADDR + 32'd4) >> 2);
`else
        return 1'b0;
`endif
    endfunction

    // Model: expected read value, or X when the addressed word was never written.
    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
`ifdef VPROC_MEM_TIMER_IRQ_EN
        if ((a >> 2) == (TMR_ADDR >> 2)) return tmr_exp;
        if ((a >> 2) == ((TMR_ADDR + 32'd4) >> 2)) return ERR_DATA;
`endif
        if (!in_window(a)) return ERR_DATA;
        idx = int'((a >> 2) % (1 << ADDR_BITS));
        if (mem_m.exists(idx)) return mem_m[idx];
        return 'x;
    endfunction

    // One VProc-style bus transaction: hold strobes until an ack is seen.
    task automatic do_txn(input bit we, input bit rd, input logic [31:0] a, input logic [31:0] d);
        int k;
        bit got;
        int w;
        logic [31:0] exp;
        @(negedge Clk);
        WE = we; RD = rd; Addr = a; DataOut = d;
        w = we ? int'(WR_WAIT) : int'(RD_WAIT);
        k = 0;
        got = 1'b0;
        while (k < 40 && !got) begin
            @(negedge Clk);
            k++;
            if (WRAck || RDAck) got = 1'b1;
        end
        WE = 1'b0; RD = 1'b0;
        check("ack_latency", k, w + 1);
        check("wrack_val", {31'd0, WRAck}, {31'd0, we});
        check("rdack_val", {31'd0, RDAck}, {31'd0, !we});
        if (we) begin
            check("datain_hold", DataIn, last_rd);
            if (in_window(a) && !is_timer(a))
                mem_m[int'((a >> 2) % (1 << ADDR_BITS))] = d;
        end else begin
            exp = model_read(a);
            if (!$isunknown(exp)) check("read_data", DataIn, exp);
            last_rd = DataIn;
        end
        @(negedge Clk);
        check("ack_width", {30'd0, WRAck, RDAck}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int unsigned r;

        Reset = 1'b1; WE = 1'b0; RD = 1'b0; Addr = '0; DataOut = '0; Update = 1'b0;
        last_rd = 32'd0;
        tmr_exp = 32'd0;
        #1;
        check("rst_datain", DataIn, 32'd0);
        check("rst_acks", {30'd0, WRAck, RDAck}, 32'd0);
        check("rst_irq", {29'd0, Interrupt}, 32'd0);
        Update = 1'b1;
        #1;
        check("upd_resp_in_reset", {31'd0, UpdateResponse}, 32'd1);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        Update = 1'b0;
        #1;
        check("upd_resp", {31'd0, UpdateResponse}, 32'd0);

        do_txn(1, 0, 32'h10, 32'h1234_5678);
        do_txn(0, 1, 32'h10, 32'h0);
        check("basic_read", DataIn, 32'h1234_5678);

        do_txn(1, 0, 32'h0, 32'h1111_0000);
        do_txn(1, 0, 32'h4, 32'h2222_0004);
        do_txn(1, 0, 32'h8, 32'h3333_0008);
        do_txn(0, 1, 32'h0, 32'h0);
        do_txn(0, 1, 32'h4, 32'h0);
        do_txn(0, 1, 32'h8, 32'h0);

        do_txn(0, 1, 32'h0001_0000, 32'h0);
        check("oow_read", DataIn, ERR_DATA);
        do_txn(1, 0, 32'h0001_0000, 32'hFFFF_FFFF);
        do_txn(0, 1, 32'h0, 32'h0);
        check("oow_write_dropped", DataIn, 32'h1111_0000);

        do_txn(1, 1, 32'h20, 32'hA5A5_A5A5);
        do_txn(0, 1, 32'h20, 32'h0);
        check("both_strobes", DataIn, 32'hA5A5_A5A5);

        // Reset during WAIT of a write: abandoned, no ack, memory untouched.
        do_txn(1, 0, 32'h30, 32'h0);
        @(negedge Clk);
        WE = 1'b1; Addr = 32'h30; DataOut = 32'hCAFE_F00D;
        @(negedge Clk);
        Reset = 1'b1; WE = 1'b0;
        #1;
        check("rst_wait_ack", {30'd0, WRAck, RDAck}, 32'd0);
        @(negedge Clk);
        check("rst_wait_ack2", {30'd0, WRAck, RDAck}, 32'd0);
        check("rst_wait_datain", DataIn, 32'd0);
        Reset = 1'b0;
        last_rd = 32'd0;
        @(negedge Clk);
        check("post_rst_ack", {30'd0, WRAck, RDAck}, 32'd0);
        do_txn(0, 1, 32'h30, 32'h0);
        check("rst_wait_mem", DataIn, 32'h0);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 80) a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            else a = {20'($urandom_range(1, 20'hFFFFE)), 12'($urandom)};
            d = $urandom;
            r = $urandom_range(0, 99);
            if (r < 45) do_txn(1, 0, a, d);
            else if (r < 90) do_txn(0, 1, a, d);
            else do_txn(1, 1, a, d);
            if ($urandom_range(0, 9) == 0) begin
                Update = ~Update;
                #1;
                check("upd_follow", {31'd0, UpdateResponse}, {31'd0, Update});
            end
            check("no_irq", {29'd0, Interrupt}, 32'd0);
        end

`ifdef VPROC_MEM_TIMER_IRQ_EN
        // do_txn returns one negedge after the ack, i.e. after commit edge C+1.
        do_txn(1, 0, TMR_ADDR, 32'h6000_0005);
        for (int i = 2; i <= 8; i++) begin
            @(negedge Clk);
            check("tmr_irq", {29'd0, Interrupt}, (i >= 5) ? 32'd3 : 32'd0);
        end
        tmr_exp = 32'h6000_0000;
        do_txn(0, 1, TMR_ADDR, 32'h0);
        check("tmr_hold", {29'd0, Interrupt}, 32'd3);
        do_txn(1, 0, TMR_ADDR + 32'd4, 32'h0);
        check("tmr_clear", {29'd0, Interrupt}, 32'd0);
        do_txn(1, 0, TMR_ADDR, 32'hE000_0000);
        tmr_exp = 32'hE000_0000;
        repeat (5) @(negedge Clk);
        check("tmr_disarmed", {29'd0, Interrupt}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
